// File: rtl/read_div_pkg.sv
// Shared types and subtractor-cell primitives for the sequential approximate divider.
package read_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned DEFAULT_N = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_N);

    // Exact cell: full subtractor.
    function automatic logic exact_d(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic exact_bo(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    // Approximate cell: passes the minuend through and ignores its borrow-in.
    function automatic logic approx_d(input logic a);
        return a;
    endfunction

    function automatic logic approx_bo(input logic a, input logic b);
        return ~a & b;
    endfunction

endpackage

// File: rtl/read_sub_row.sv
// One combinational masked subtractor row: N selectable cells plus an exact top cell with b=0.
module read_sub_row
    import read_div_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   t,
    input  logic [N-1:0] y,
    input  logic [N-1:0] mask,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout
);

    logic borrow;
    logic bo_cell;

    always_comb begin
        d       = '0;
        borrow  = bin;
        bo_cell = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mask[i]) begin
                d[i]    = exact_d(t[i], y[i], borrow);
                bo_cell = exact_bo(t[i], y[i], borrow);
            end else begin
                d[i]    = approx_d(t[i]);
                bo_cell = approx_bo(t[i], y[i]);
            end
            borrow = bo_cell;
        end
        // The top cell's difference is not needed by a restoring divider, only its borrow.
        bout = exact_bo(t[N], 1'b0, borrow);
    end

endmodule

// File: rtl/read_div_seq.sv
// Sequential 2N/N approximate restoring divider, one masked subtraction row per clock.
module read_div_seq
    import read_div_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   x,
    input  logic [N-1:0]     y,
    input  logic             bin,
    input  logic [N*N-1:0]   app,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     q,
    output logic [N-1:0]     r,
    output logic             dz,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(N);

    state_e           state_q, state_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     low_q, low_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     r_q, r_d;
    logic [N-1:0]     y_q, y_d;
    logic             bin_q, bin_d;
    logic [N*N-1:0]   app_q, app_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [N:0]       row_t;
    logic [N-1:0]     row_mask;
    logic [N-1:0]     row_d;
    logic             row_bout;
    logic [N-1:0]     rem_next;

    assign row_t    = {rem_q, low_q[N-1]};
    assign row_mask = app_q[N*cnt_q +: N];

    read_sub_row #(.N(N)) u_row (
        .t    (row_t),
        .y    (y_q),
        .mask (row_mask),
        .bin  (bin_q),
        .d    (row_d),
        .bout (row_bout)
    );

    assign rem_next = row_bout ? row_t[N-1:0] : row_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        low_d   = low_q;
        q_d     = q_q;
        r_d     = r_q;
        y_d     = y_q;
        bin_d   = bin_q;
        app_d   = app_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d   = y;
                    bin_d = bin;
                    app_d = app;
                    rem_d = x[2*N-1:N];
                    low_d = x[N-1:0];
                    cnt_d = '0;
                    if (y == '0) begin
                        dz_d    = 1'b1;
                        q_d     = '1;
                        r_d     = x[N-1:0];
                        state_d = DONE;
                    end else if (x[2*N-1:N] >= y) begin
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = x[N-1:0];
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                low_d = low_q << 1;
                q_d   = {q_q[N-2:0], ~row_bout};
                rem_d = rem_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    r_d     = rem_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            low_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            bin_q   <= 1'b0;
            app_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            q_q     <= q_d;
            r_q     <= r_d;
            y_q     <= y_d;
            bin_q   <= bin_d;
            app_q   <= app_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule
